// File: rtl/uart_tx_datapath.sv
// UART TX datapath: byte capture, parity generation, LSB-first serializer and registered line driver.
// Optional compile-time feature UART_TX_BREAK_EN adds Break_Req, which forces the line low while held.

module uart_tx_datapath #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_TYP,
    input  logic                  Busy,
    input  logic                  Ser_En,
    input  logic [1:0]            MUX_Sel,
`ifdef UART_TX_BREAK_EN
    input  logic                  Break_Req,
`endif
    output logic                  Ser_Done,
    output logic                  TX_OUT
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_DATA   = 2'b01;
    localparam logic [1:0] SEL_PARITY = 2'b11;

    generate
        if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_width_check
            $error("uart_tx_datapath: DATA_WIDTH must be in 5..9");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  par_bit;
    logic                  load;
    logic                  shift;
    logic                  line_next;

    // Load has priority over a shift strobe in the same cycle.
    assign load  = Data_Valid && !Busy;
    assign shift = Ser_En && !load && (bit_cnt != CNT_FULL);

    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            par_bit   <= 1'b0;
        end else if (load) begin
            shift_reg <= P_DATA;
            bit_cnt   <= '0;
            par_bit   <= (^P_DATA) ^ PAR_TYP;
        end else if (shift) begin
            shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
            bit_cnt   <= bit_cnt + CNT_W'(1);
        end
    end

    assign Ser_Done = (bit_cnt == CNT_FULL);

    // Data source uses the pre-shift LSB, so the bit leaving the register lands on the line.
    always_comb begin
        line_next = 1'b1;
        case (MUX_Sel)
            SEL_START:  line_next = 1'b0;
            SEL_DATA:   line_next = shift_reg[0];
            SEL_PARITY: line_next = par_bit;
            default:    line_next = 1'b1;
        endcase
`ifdef UART_TX_BREAK_EN
        if (Break_Req) begin
            line_next = 1'b0;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            TX_OUT <= 1'b1;
        end else begin
            TX_OUT <= line_next;
        end
    end

endmodule
